lc_port_arbiter: RTL and testbench
==================================

# lc_port_arbiter

Shares the single L2 (lower-cache) port between the L1 data cache and the L1 instruction cache. It sits between both L1 `lc_*` interfaces and the L2 request/response port. It accepts one miss or writeback at a time under round-robin arbitration, registers it onto the L2 port, and records the owner of every read. Responses are routed back in order.

## Interface
- `PADDR_BITS`, 19, physical address width
- `B`, 64, line size in bytes; line data width is 8*B
- `OUTSTANDING`, 4, maximum reads in flight to L2 (power of two, ≥2)
- `clk_in` in 1: single clock
- `rst_in` in 1: reset, synchronous, active-high
- `cs_N_in` in 1: chip select, active-low; when high, no new grants (in-flight traffic still completes)
- `l1d_valid_in` in 1: L1D request valid
- `l1d_we_in` in 1: L1D request is writeback (no response expected)
- `l1d_addr_in` in PADDR_BITS: L1D request address
- `l1d_value_in` in 8*B: L1D writeback data
- `l1d_ready_out` out 1: L1D request accepted this cycle
- `l1d_valid_out` out 1: fill response to L1D valid
- `l1d_ready_in` in 1: L1D can take a fill
- `l1d_addr_out` out PADDR_BITS: fill address to L1D
- `l1d_value_out` out 8*B: fill data to L1D
- `l1i_valid_in`, `l1i_addr_in`, `l1i_ready_out`, `l1i_valid_out`, `l1i_ready_in`, `l1i_addr_out`, `l1i_value_out`: same as the L1D ports. L1I is read-only, so it has no `we` or value input.
- `l2_valid_out` out 1, `l2_ready_in` in 1, `l2_addr_out` out PADDR_BITS, `l2_value_out` out 8*B, `l2_we_out` out 1: request to L2
- `l2_valid_in` in 1, `l2_ready_out` out 1, `l2_addr_in` in PADDR_BITS, `l2_value_in` in 8*B: L2 response, returned in request order
- `orphan_resp_out` out 1: sticky; set when a response arrives with no read outstanding

## Operation
- FSM with two states:
  - IDLE: arbitrate.
  - SEND: hold the registered request on L2 until `l2_ready_in`.
- Eligibility in IDLE: requester valid, `cs_N_in`=0, and either the request is a write or the owner FIFO is not full.
- Round-robin arbitration: `last_grant` bit; the requester other than `last_grant` wins a tie. Reset value 1, so L1D wins the first tie.
- Grant (IDLE, eligible):
  - `*_ready_out`=1 for the winner only, combinationally, in that cycle.
  - addr/value/we are captured into the holding register.
  - Reads push the owner ID (0=L1D, 1=L1I) into the owner FIFO.
  - `last_grant` is updated; the FSM moves to SEND.
- SEND:
  - `l2_valid_out`=1 with the held fields.
  - On `l2_ready_in`, go to IDLE.
  - No new grant in the same cycle, so the port accepts at most one request per 2 cycles.
- Response routing:
  - With the FIFO non-empty, `l2_valid_in` drives `valid_out` of the head owner combinationally; the other port's valid stays 0.
  - addr/value are broadcast to both ports.
  - `l2_ready_out` = head owner's `ready_in`.
  - On handshake, pop the FIFO.
- Orphan response (FIFO empty, `l2_valid_in`=1): `l2_ready_out`=1, the response is dropped, `orphan_resp_out` is set until reset.
- Simultaneous response pop and grant push: both take effect; occupancy is unchanged, including when the FIFO is full.
- Full FIFO: a read request waits and a write from the other port may be granted. A write from the same port may bypass its stalled read.
- Reset mid-transaction: the holding register is dropped, the FIFO is emptied, the FSM returns to IDLE, and `last_grant` is set to 1. Responses that arrive later for requests issued before reset are orphans.

## Timing
- Reset values: all `valid_out` and `ready_out` 0, `l2_we_out` 0, all addr/value outputs 0, `orphan_resp_out` 0, state IDLE.
- Request latency:
  - Granted at cycle t; `l2_valid_out`=1 at t+1.
  - L2 handshake at t+1 at the earliest; next grant at t+2.
- Response path: zero-cycle combinational pass-through from L2 to the L1 port.
- Held request fields must not change while `l2_valid_out`=1.

## Configuration
- `LC_ARB_PERF_EN` defined:
  - adds 32-bit wrapping counters `perf_l1d_grants_out`, `perf_l1i_grants_out`, `perf_full_stall_out`;
  - the stall counter increments each cycle a read is blocked solely by a full FIFO;
  - all counters clear on `rst_in`.
- Not defined: counter ports and logic are absent; functional behaviour is identical.

## Structure
- Package `lc_arb_pkg`: `owner_e` enum (`OWNER_L1D`=0, `OWNER_L1I`=1), `arb_state_e` (IDLE, SEND), request struct typedef.
- Sub-module `owner_fifo`: synchronous FIFO, depth OUTSTANDING, 1-bit entries, full/empty flags, simultaneous push/pop.

## Test plan
- L1D read to 0x00100 alone:
  - `l1d_ready_out` in the grant cycle; next cycle `l2_addr_out`=0x00100, `l2_we_out`=0.
  - L2 responds with value 0xAB..AB → only `l1d_valid_out`=1, value matches.
- L1D and L1I both valid every cycle after reset → grants alternate L1D, L1I, L1D, L1I.
- Four L1I reads outstanding, no responses:
  - a fifth L1I read stalls;
  - an L1D writeback to 0x00200 is still granted with `l2_we_out`=1;
  - one response frees a slot.
- Read order L1D 0x40, L1I 0x80, L1D 0xC0 → responses route D, I, D.
  - Hold `l1i_ready_in`=0 on the second response → `l2_ready_out`=0 until it is raised.
- `l2_valid_in` with the FIFO empty → `l2_ready_out`=1, no L1 valid, `orphan_resp_out`=1 until reset.
- `rst_in` asserted while in SEND with 2 reads outstanding → next cycle `l2_valid_out`=0 and the FIFO is empty. The following L1D read is granted normally.

Source files
------------

// File: rtl/lc_arb_pkg.sv
// lc_arb_pkg: shared types for the L1D/L1I -> L2 port arbiter.
//   owner_e     : which L1 issued a read (also the owner FIFO entry)
//   arb_state_e : arbiter FSM states
//   lc_req_t    : request held on the L2 port while in SEND
package lc_arb_pkg;

    localparam int LC_PADDR_BITS  = 19;
    localparam int LC_B           = 64;
    localparam int LC_LINE_BITS   = 8 * LC_B;
    localparam int LC_OUTSTANDING = 4;

    typedef enum logic {
        OWNER_L1D = 1'b0,
        OWNER_L1I = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    // Widths follow the package defaults; the top's parameters default to
    // the same values.
    typedef struct packed {
        logic                     we;
        logic [LC_PADDR_BITS-1:0] addr;
        logic [LC_LINE_BITS-1:0]  value;
    } lc_req_t;

endpackage

// File: rtl/owner_fifo.sv
// owner_fifo: records which L1 owns each outstanding L2 read, oldest first.
//   clk_in, rst_in  : clock, synchronous active-high reset (empties FIFO)
//   push, push_owner: enqueue an owner ID
//   pop             : dequeue the head (ignored when empty)
//   head            : owner of the oldest outstanding read
//   full, empty     : occupancy flags
// Push and pop in the same cycle both take effect, even when full.
module owner_fifo
    import lc_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    output owner_e head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = owner_e'(mem[rd_ptr[AW-1:0]]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_owner;
    end

endmodule

// File: rtl/lc_port_arbiter.sv
// lc_port_arbiter: shares one L2 port between L1D and L1I.
//   clk_in, rst_in     : clock, synchronous active-high reset
//   cs_N_in            : active-low chip select; high blocks new grants only
//   l1d_* / l1i_*      : L1 request side (valid/we/addr/value in, ready out)
//                        and fill side (valid/addr/value out, ready in)
//   l2_*_out / l2_ready_in : registered request to L2
//   l2_*_in / l2_ready_out : in-order L2 responses, routed combinationally
//   orphan_resp_out    : sticky, a response arrived with no read outstanding
// Optional macro LC_ARB_PERF_EN adds perf_l1d_grants_out,
// perf_l1i_grants_out and perf_full_stall_out counters.
module lc_port_arbiter
    import lc_arb_pkg::*;
#(
    parameter int PADDR_BITS  = LC_PADDR_BITS,
    parameter int B           = LC_B,
    parameter int OUTSTANDING = LC_OUTSTANDING
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cs_N_in,
    input  logic                  l1d_valid_in,
    input  logic                  l1d_we_in,
    input  logic [PADDR_BITS-1:0] l1d_addr_in,
    input  logic [8*B-1:0]        l1d_value_in,
    output logic                  l1d_ready_out,
    output logic                  l1d_valid_out,
    input  logic                  l1d_ready_in,
    output logic [PADDR_BITS-1:0] l1d_addr_out,
    output logic [8*B-1:0]        l1d_value_out,
    input  logic                  l1i_valid_in,
    input  logic [PADDR_BITS-1:0] l1i_addr_in,
    output logic                  l1i_ready_out,
    output logic                  l1i_valid_out,
    input  logic                  l1i_ready_in,
    output logic [PADDR_BITS-1:0] l1i_addr_out,
    output logic [8*B-1:0]        l1i_value_out,
    output logic                  l2_valid_out,
    input  logic                  l2_ready_in,
    output logic [PADDR_BITS-1:0] l2_addr_out,
    output logic [8*B-1:0]        l2_value_out,
    output logic                  l2_we_out,
    input  logic                  l2_valid_in,
    output logic                  l2_ready_out,
    input  logic [PADDR_BITS-1:0] l2_addr_in,
    input  logic [8*B-1:0]        l2_value_in,
    output logic                  orphan_resp_out
`ifdef LC_ARB_PERF_EN
    ,
    output logic [31:0]           perf_l1d_grants_out,
    output logic [31:0]           perf_l1i_grants_out,
    output logic [31:0]           perf_full_stall_out
`endif
);
    arb_state_e state, state_nxt;
    owner_e     last_grant;
    lc_req_t    hold;
    logic       d_elig, i_elig, grant_d, grant_i;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    owner_e     fifo_head;

    // Reads need a free owner slot; writebacks never get a response.
    assign d_elig = !rst_in && !cs_N_in && l1d_valid_in && (l1d_we_in || !fifo_full);
    assign i_elig = !rst_in && !cs_N_in && l1i_valid_in && !fifo_full;

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not win last time goes.
                grant_d = d_elig && (!i_elig || last_grant == OWNER_L1I);
                grant_i = i_elig && (!d_elig || last_grant == OWNER_L1D);
                if (grant_d || grant_i) state_nxt = SEND;
            end
            SEND:    if (l2_ready_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            last_grant      <= OWNER_L1I;
            hold            <= '0;
            orphan_resp_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                hold       <= '{we: l1d_we_in, addr: l1d_addr_in, value: l1d_value_in};
                last_grant <= OWNER_L1D;
            end else if (grant_i) begin
                hold       <= '{we: 1'b0, addr: l1i_addr_in, value: '0};
                last_grant <= OWNER_L1I;
            end
            if (l2_valid_in && fifo_empty) orphan_resp_out <= 1'b1;
        end
    end

    assign l1d_ready_out = grant_d;
    assign l1i_ready_out = grant_i;
    assign l2_valid_out  = (state == SEND);
    assign l2_we_out     = hold.we;
    assign l2_addr_out   = hold.addr;
    assign l2_value_out  = hold.value;

    assign fifo_push = (grant_d && !l1d_we_in) || grant_i;
    assign fifo_pop  = l2_valid_in && l2_ready_out;

    owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (fifo_push),
        .push_owner (grant_i ? OWNER_L1I : OWNER_L1D),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Orphans are always accepted and dropped so L2 never wedges.
    assign l1d_valid_out = l2_valid_in && !fifo_empty && (fifo_head == OWNER_L1D);
    assign l1i_valid_out = l2_valid_in && !fifo_empty && (fifo_head == OWNER_L1I);
    assign l2_ready_out  = fifo_empty ? l2_valid_in
                         : (fifo_head == OWNER_L1D) ? l1d_ready_in : l1i_ready_in;
    assign l1d_addr_out  = l2_addr_in;
    assign l1d_value_out = l2_value_in;
    assign l1i_addr_out  = l2_addr_in;
    assign l1i_value_out = l2_value_in;

`ifdef LC_ARB_PERF_EN
    logic full_stall;
    assign full_stall = (state == IDLE) && !cs_N_in && fifo_full &&
                        ((l1d_valid_in && !l1d_we_in) || l1i_valid_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_l1d_grants_out <= '0;
            perf_l1i_grants_out <= '0;
            perf_full_stall_out <= '0;
        end else begin
            if (grant_d)    perf_l1d_grants_out <= perf_l1d_grants_out + 32'd1;
            if (grant_i)    perf_l1i_grants_out <= perf_l1i_grants_out + 32'd1;
            if (full_stall) perf_full_stall_out <= perf_full_stall_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lc_port_arbiter.sv
module tb_lc_port_arbiter;
    localparam int PA = 19;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs_n;
    logic          d_vi, d_we, d_ri, i_vi, i_ri;
    logic [PA-1:0] d_ai, i_ai, l2_ai;
    logic [LW-1:0] d_wi, l2_wi;
    logic          d_ro, d_vo, i_ro, i_vo;
    logic [PA-1:0] d_ao, i_ao, l2_ao;
    logic [LW-1:0] d_wo, i_wo, l2_wo;
    logic          l2_vo, l2_ri, l2_weo, l2_vi, l2_ro, orphan;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lc_port_arbiter dut (
        .clk_in(clk), .rst_in(rst), .cs_N_in(cs_n),
        .l1d_valid_in(d_vi), .l1d_we_in(d_we), .l1d_addr_in(d_ai), .l1d_value_in(d_wi),
        .l1d_ready_out(d_ro), .l1d_valid_out(d_vo), .l1d_ready_in(d_ri),
        .l1d_addr_out(d_ao), .l1d_value_out(d_wo),
        .l1i_valid_in(i_vi), .l1i_addr_in(i_ai), .l1i_ready_out(i_ro),
        .l1i_valid_out(i_vo), .l1i_ready_in(i_ri), .l1i_addr_out(i_ao), .l1i_value_out(i_wo),
        .l2_valid_out(l2_vo), .l2_ready_in(l2_ri), .l2_addr_out(l2_ao),
        .l2_value_out(l2_wo), .l2_we_out(l2_weo),
        .l2_valid_in(l2_vi), .l2_ready_out(l2_ro), .l2_addr_in(l2_ai), .l2_value_in(l2_wi),
        .orphan_resp_out(orphan)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cs_n = 1'b0; d_vi = 1'b0; d_we = 1'b0; d_ai = '0; d_wi = '0; d_ri = 1'b1;
        i_vi = 1'b0; i_ai = '0; i_ri = 1'b1;
        l2_ri = 1'b1; l2_vi = 1'b0; l2_ai = '0; l2_wi = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values
        clear_inputs();
        l2_ri = 1'b0;
        cyc();
        #1;
        chk("rst_l2_valid", l2_vo, 0);
        chk("rst_l2_we", l2_weo, 0);
        chk("rst_l2_addr", l2_ao, 0);
        chk("rst_l2_value", l2_wo, 0);
        chk("rst_l2_ready", l2_ro, 0);
        chk("rst_d_valid", d_vo, 0);
        chk("rst_i_valid", i_vo, 0);
        chk("rst_d_ready", d_ro, 0);
        chk("rst_i_ready", i_ro, 0);
        chk("rst_orphan", orphan, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // ---- chip select blocks grants
        cs_n = 1'b1; d_vi = 1'b1; d_ai = 19'h00100;
        #1 chk("cs_block_ready", d_ro, 0);
        cyc();
        chk("cs_block_l2", l2_vo, 0);

        // ---- single L1D read to 0x00100
        cs_n = 1'b0; l2_ri = 1'b0;
        #1 chk("rd_d_ready", d_ro, 1);
        chk("rd_i_ready", i_ro, 0);
        cyc();
        d_vi = 1'b0;
        #1 chk("rd_l2_valid", l2_vo, 1);
        chk("rd_l2_addr", l2_ao, 19'h00100);
        chk("rd_l2_we", l2_weo, 0);
        chk("rd_send_no_grant", d_ro, 0);
        cyc();
        chk("rd_hold_valid", l2_vo, 1);
        chk("rd_hold_addr", l2_ao, 19'h00100);
        l2_ri = 1'b1;
        cyc();
        l2_ri = 1'b0;
        #1 chk("rd_l2_idle", l2_vo, 0);
        l2_vi = 1'b1; l2_ai = 19'h00100; l2_wi = {64{8'hAB}};
        #1 chk("rsp_d_valid", d_vo, 1);
        chk("rsp_i_valid", i_vo, 0);
        chk("rsp_d_value", d_wo, {64{8'hAB}});
        chk("rsp_d_addr", d_ao, 19'h00100);
        chk("rsp_l2_ready", l2_ro, 1);
        cyc();
        l2_vi = 1'b0;

        // ---- round robin, both valid every cycle
        do_reset();
        d_vi = 1'b1; d_ai = 19'h00011; i_vi = 1'b1; i_ai = 19'h00022;
        #1 chk("rr1_d", d_ro, 1);
        chk("rr1_i", i_ro, 0);
        cyc();
        chk("rr1_l2_addr", l2_ao, 19'h00011);
        chk("rr_send_d", d_ro, 0);
        chk("rr_send_i", i_ro, 0);
        cyc();
        chk("rr2_i", i_ro, 1);
        chk("rr2_d", d_ro, 0);
        cyc();
        chk("rr2_l2_addr", l2_ao, 19'h00022);
        cyc();
        chk("rr3_d", d_ro, 1);
        chk("rr3_i", i_ro, 0);
        cyc();
        cyc();
        chk("rr4_i", i_ro, 1);
        chk("rr4_d", d_ro, 0);
        cyc();
        cyc();
        chk("rr_full_d", d_ro, 0);
        chk("rr_full_i", i_ro, 0);
        d_vi = 1'b0; i_vi = 1'b0;

        // ---- four L1I reads outstanding, write still granted
        do_reset();
        for (int k = 0; k < 4; k++) begin
            i_vi = 1'b1; i_ai = 19'h01000 + 19'(k);
            #1 chk("fill_i_ready", i_ro, 1);
            cyc();
            cyc();
        end
        chk("full_i_stall", i_ro, 0);
        d_vi = 1'b1; d_we = 1'b1; d_ai = 19'h00200; d_wi = {16{32'hDEAD_BEEF}};
        #1 chk("full_wb_ready", d_ro, 1);
        chk("full_wb_i_ready", i_ro, 0);
        cyc();
        d_vi = 1'b0; d_we = 1'b0;
        #1 chk("full_wb_l2_we", l2_weo, 1);
        chk("full_wb_l2_addr", l2_ao, 19'h00200);
        chk("full_wb_l2_value", l2_wo, {16{32'hDEAD_BEEF}});
        cyc();
        chk("full_i_stall2", i_ro, 0);
        l2_vi = 1'b1; l2_ai = 19'h01000;
        #1 chk("full_rsp_i", i_vo, 1);
        chk("full_rsp_d", d_vo, 0);
        cyc();
        l2_vi = 1'b0;
        #1 chk("slot_freed_i", i_ro, 1);
        cyc();
        i_vi = 1'b0;
        cyc();

        // ---- in-order routing D, I, D with L1I back-pressure
        do_reset();
        d_vi = 1'b1; d_ai = 19'h00040;
        cyc(); d_vi = 1'b0; cyc();
        i_vi = 1'b1; i_ai = 19'h00080;
        cyc(); i_vi = 1'b0; cyc();
        d_vi = 1'b1; d_ai = 19'h000C0;
        cyc(); d_vi = 1'b0; cyc();
        l2_vi = 1'b1; l2_ai = 19'h00040; l2_wi = {64{8'h11}}; d_ri = 1'b1; i_ri = 1'b0;
        #1 chk("ord1_d", d_vo, 1);
        chk("ord1_i", i_vo, 0);
        chk("ord1_l2_ready", l2_ro, 1);
        cyc();
        l2_ai = 19'h00080; l2_wi = {64{8'h22}};
        #1 chk("ord2_i", i_vo, 1);
        chk("ord2_d", d_vo, 0);
        chk("ord2_bp", l2_ro, 0);
        cyc();
        chk("ord2_bp_hold", l2_ro, 0);
        chk("ord2_i_hold", i_vo, 1);
        i_ri = 1'b1;
        #1 chk("ord2_release", l2_ro, 1);
        chk("ord2_i_addr", i_ao, 19'h00080);
        chk("ord2_i_value", i_wo, {64{8'h22}});
        cyc();
        l2_ai = 19'h000C0;
        #1 chk("ord3_d", d_vo, 1);
        chk("ord3_i", i_vo, 0);
        cyc();
        l2_vi = 1'b0;

        // ---- orphan response
        l2_vi = 1'b1; d_ri = 1'b0; i_ri = 1'b0;
        #1 chk("orph_l2_ready", l2_ro, 1);
        chk("orph_d_valid", d_vo, 0);
        chk("orph_i_valid", i_vo, 0);
        chk("orph_before_edge", orphan, 0);
        cyc();
        l2_vi = 1'b0;
        #1 chk("orph_set", orphan, 1);
        cyc();
        chk("orph_sticky", orphan, 1);
        do_reset();
        #1 chk("orph_cleared", orphan, 0);

        // ---- reset while in SEND with two reads outstanding
        d_vi = 1'b1; d_ai = 19'h00010;
        cyc(); d_vi = 1'b0; cyc();
        l2_ri = 1'b0; i_vi = 1'b1; i_ai = 19'h00020;
        cyc();
        i_vi = 1'b0;
        #1 chk("mid_send_valid", l2_vo, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        l2_vi = 1'b1; d_ri = 1'b0; i_ri = 1'b0;
        #1 chk("mid_rst_l2_valid", l2_vo, 0);
        chk("mid_rst_fifo_empty", l2_ro, 1);
        chk("mid_rst_no_d", d_vo, 0);
        chk("mid_rst_no_i", i_vo, 0);
        cyc();
        l2_vi = 1'b0; l2_ri = 1'b1; d_ri = 1'b1; i_ri = 1'b1;
        d_vi = 1'b1; d_ai = 19'h00300;
        #1 chk("post_rst_grant", d_ro, 1);
        cyc();
        d_vi = 1'b0;
        #1 chk("post_rst_l2_valid", l2_vo, 1);
        chk("post_rst_l2_addr", l2_ao, 19'h00300);
        chk("post_rst_l2_we", l2_weo, 0);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
